// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the runtime-programmable frequency divider.
package freq_div_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Smallest ratio that still yields a distinct high and low phase.
    localparam int unsigned MIN_RATIO = 2;

    // High-phase length of a divided waveform: ceiling of ratio/2, so odd
    // ratios spend the extra cycle high.
    function automatic int unsigned half_ratio(input int unsigned ratio);
        return (ratio + 1) >> 1;
    endfunction

endpackage

// File: rtl/freq_div_cnt.sv
// Wrapping period counter with registered divided-clock and enable decode.
module freq_div_cnt
    import freq_div_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         load0,
    input  logic [W-1:0] ratio,
    output logic         wrap,
    output logic         div_out,
    output logic         clk_en
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] last_cnt;
    logic [W-1:0] high_len;
    logic         div_out_q, div_out_d;
    logic         clk_en_q, clk_en_d;

    // Next count and output decode; outputs lag the count by one cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        last_cnt  = ratio - W'(1);
        high_len  = W'(half_ratio(32'(ratio)));
        wrap      = run && (cnt_q == last_cnt);
        cnt_d     = cnt_q + W'(1);
        if (load0 || !run || wrap) begin
            cnt_d = '0;
        end
        div_out_d = run && (cnt_q < high_len);
        clk_en_d  = wrap;
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low, so it is just the first
        // branch of the clocked block; state updates use non-blocking
        // assignments so all flops sample the same pre-edge values.
        if (!rst) begin
            cnt_q     <= '0;
            div_out_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_out_q <= div_out_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign div_out = div_out_q;
    assign clk_en  = clk_en_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// Runtime-programmable divider: FSM, ratio change handshake and ratio regs.
// Ratio changes are applied only on a period boundary, so no runt periods.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int W         = 4,
    parameter int DEF_RATIO = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         div_req,
    input  logic [W-1:0] div_ratio,
    output logic         div_ack,
    output logic         div_err,
    output logic         busy,
    output logic [W-1:0] cur_ratio,
    output logic         div_out,
    output logic         clk_en
);

    localparam logic [W-1:0] DEF_R = W'(DEF_RATIO);
    localparam logic [W-1:0] MIN_R = W'(MIN_RATIO);

    state_t       state_q, state_d;
    logic [W-1:0] cur_ratio_q, cur_ratio_d;
    logic [W-1:0] pend_ratio_q, pend_ratio_d;
    logic         busy_q, busy_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         req_live;
    logic         req_good;
    logic         wrap;
    logic         cnt_run;
    logic         cnt_load0;

    assign cnt_run   = (state_q != OFF);
    assign cnt_load0 = (state_q == OFF);

    freq_div_cnt #(
        .W (W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .run     (cnt_run),
        .load0   (cnt_load0),
        .ratio   (cur_ratio_q),
        .wrap    (wrap),
        .div_out (div_out),
        .clk_en  (clk_en)
    );

    // Next-state logic: request evaluation, boundary ratio swap, run/drain.
    always_comb begin
        state_d      = state_q;
        cur_ratio_d  = cur_ratio_q;
        pend_ratio_d = pend_ratio_q;
        busy_d       = busy_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;

        // The cycle showing ack/err belongs to the old request; a request
        // still high after that one is a new request.
        req_live = div_req && !ack_q && !err_q &&
                   ((state_q == OFF) || (state_q == RUN));
        req_good = req_live && (div_ratio >= MIN_R);

        if (req_good) begin
            pend_ratio_d = div_ratio;
            ack_d        = 1'b1;
        end else if (req_live) begin
            err_d = 1'b1;
        end

        case (state_q)
            OFF: begin
                if (req_good) begin
                    cur_ratio_d = div_ratio;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (req_good) begin
                    busy_d  = 1'b1;
                    state_d = en ? PEND : DRAIN;
                end else if (!en) begin
                    state_d = DRAIN;
                end
            end
            PEND: begin
                if (wrap) begin
                    cur_ratio_d = pend_ratio_q;
                    busy_d      = 1'b0;
                    state_d     = en ? RUN : DRAIN;
                end else if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    if (busy_q) begin
                        cur_ratio_d = pend_ratio_q;
                    end
                    busy_d  = 1'b0;
                    state_d = OFF;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // FSM, ratio and handshake registers; reset drops any pending change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= OFF;
            cur_ratio_q  <= DEF_R;
            pend_ratio_q <= DEF_R;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_ratio_q  <= cur_ratio_d;
            pend_ratio_q <= pend_ratio_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign div_ack   = ack_q;
    assign div_err   = err_q;
    assign busy      = busy_q;
    assign cur_ratio = cur_ratio_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed testbench for freq_div_ctrl (W = 4, DEF_RATIO = 2).
module tb_freq_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       div_req;
    logic [3:0] div_ratio;
    logic       div_ack;
    logic       div_err;
    logic       busy;
    logic [3:0] cur_ratio;
    logic       div_out;
    logic       clk_en;

    int n_checks = 0;
    int n_fail   = 0;

    freq_div_ctrl #(
        .W         (4),
        .DEF_RATIO (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_req   (div_req),
        .div_ratio (div_ratio),
        .div_ack   (div_ack),
        .div_err   (div_err),
        .busy      (busy),
        .cur_ratio (cur_ratio),
        .div_out   (div_out),
        .clk_en    (clk_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       req;
        logic [3:0] ratio;
        logic       dout;
        logic       ce;
        logic       ack;
        logic       err;
        logic       busy;
        logic [3:0] cur;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int r, input int e, input int q, input int rat,
                               input int d, input int c, input int a, input int er,
                               input int b, input int cr);
        vec_t t;
        t.rst   = r[0];
        t.en    = e[0];
        t.req   = q[0];
        t.ratio = rat[3:0];
        t.dout  = d[0];
        t.ce    = c[0];
        t.ack   = a[0];
        t.err   = er[0];
        t.busy  = b[0];
        t.cur   = cr[3:0];
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until cur_ratio reaches r, bounded; reports the steps taken.
    task automatic wait_cur(input logic [3:0] r, input int budget, output int n);
        n = 0;
        while (cur_ratio !== r && n < budget) begin
            step();
            n++;
        end
        check("wait_cur_ratio", 8'(cur_ratio), 8'(r));
    endtask

    // Count cycles until the next clk_en pulse, bounded.
    task automatic measure_gap(input string name, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (clk_en !== 1'b1 && n < exp + 4);
        check(name, 8'(n), 8'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] drain_exp [8];
        int         n;

        rst       = 1'b0;
        en        = 1'b0;
        div_req   = 1'b0;
        div_ratio = 4'd0;

        //            rst en req rat | dout ce ack err busy cur
        // Reset, then start at the default ratio 2.
        vecs.push_back(v(0, 0, 0, 0,   0, 0, 0, 0, 0, 2));
        vecs.push_back(v(0, 1, 0, 0,   0, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 1, 0, 0,   0, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 2));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 2));
        // Rejected ratio 1 while running.
        vecs.push_back(v(1, 1, 1, 1,   1, 0, 0, 1, 0, 2));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 2));
        // Disable: drain the last period, then OFF.
        vecs.push_back(v(1, 0, 0, 0,   1, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 0,   0, 1, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 0,   0, 0, 0, 0, 0, 2));
        // Ratio 5 requested in OFF applies at once; req held one cycle extra.
        vecs.push_back(v(1, 0, 1, 5,   0, 0, 1, 0, 0, 5));
        vecs.push_back(v(1, 1, 1, 5,   0, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   0, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   0, 0, 0, 0, 0, 5));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 5));
        // Switch 5 -> 7 while running, applied at the boundary.
        vecs.push_back(v(1, 1, 1, 7,   1, 0, 1, 0, 1, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 1, 5));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 1, 5));
        vecs.push_back(v(1, 1, 0, 0,   0, 0, 0, 0, 1, 5));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 7));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 7));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 7));
        // Request 3 at cnt = 2 of a 7-cycle period.
        vecs.push_back(v(1, 1, 1, 3,   1, 0, 1, 0, 1, 7));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 1, 7));
        vecs.push_back(v(1, 1, 0, 0,   0, 0, 0, 0, 1, 7));
        vecs.push_back(v(1, 1, 0, 0,   0, 0, 0, 0, 1, 7));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0,   1, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0,   0, 1, 0, 0, 0, 3));

        #2;
        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            en        = vecs[i].en;
            div_req   = vecs[i].req;
            div_ratio = vecs[i].ratio;
            step();
            check($sformatf("row%0d_div_out", i), 8'(div_out),   8'(vecs[i].dout));
            check($sformatf("row%0d_clk_en", i),  8'(clk_en),    8'(vecs[i].ce));
            check($sformatf("row%0d_div_ack", i), 8'(div_ack),   8'(vecs[i].ack));
            check($sformatf("row%0d_div_err", i), 8'(div_err),   8'(vecs[i].err));
            check($sformatf("row%0d_busy", i),    8'(busy),      8'(vecs[i].busy));
            check($sformatf("row%0d_cur", i),     8'(cur_ratio), 8'(vecs[i].cur));
        end

        // Stalled request: running at 3 with cnt = 0, request 4, then raise a
        // second request for 6 while the first is still pending.
        div_req = 1'b1; div_ratio = 4'd4;
        step();
        check("stall_first_ack", 8'(div_ack), 8'd1);
        check("stall_first_busy", 8'(busy), 8'd1);
        div_req = 1'b0;
        step();
        check("stall_ack_drop", 8'(div_ack), 8'd0);
        div_req = 1'b1; div_ratio = 4'd6;
        step();
        check("stall_no_ack_at_boundary", 8'(div_ack), 8'd0);
        check("stall_boundary_cur", 8'(cur_ratio), 8'd4);
        check("stall_boundary_busy", 8'(busy), 8'd0);
        check("stall_boundary_clk_en", 8'(clk_en), 8'd1);
        step();
        check("stall_second_ack", 8'(div_ack), 8'd1);
        check("stall_second_busy", 8'(busy), 8'd1);
        div_req = 1'b0;
        // Old period of 4 completes (1 cycle already elapsed), then 6.
        wait_cur(4'd6, 12, n);
        check("switch_old_tail_len", 8'(n), 8'd3);
        check("switch_busy_fall", 8'(busy), 8'd0);
        check("switch_clk_en", 8'(clk_en), 8'd1);
        measure_gap("gap_new_ratio_6", 6);

        // Disable drain at ratio 6: cnt = 0 now; drop en when cnt = 1.
        drain_exp = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        step();
        for (int i = 0; i < 8; i++) begin
            en = 1'b0;
            step();
            check($sformatf("drain%0d_div_out", i), 8'(div_out), 8'(drain_exp[i][1]));
            check($sformatf("drain%0d_clk_en", i),  8'(clk_en),  8'(drain_exp[i][0]));
        end
        check("drain_cur", 8'(cur_ratio), 8'd6);

        // Reset while a change is pending discards it.
        en = 1'b1;
        step();
        div_req = 1'b1; div_ratio = 4'd5;
        step();
        check("pend_busy_before_reset", 8'(busy), 8'd1);
        div_req = 1'b0;
        rst     = 1'b0;
        step();
        check("rst_div_out", 8'(div_out), 8'd0);
        check("rst_clk_en", 8'(clk_en), 8'd0);
        check("rst_div_ack", 8'(div_ack), 8'd0);
        check("rst_div_err", 8'(div_err), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_cur", 8'(cur_ratio), 8'd2);
        rst = 1'b1;
        step();
        check("restart_off_div_out", 8'(div_out), 8'd0);
        measure_gap("restart_gap_first", 2);
        measure_gap("restart_gap_second", 2);
        check("restart_cur", 8'(cur_ratio), 8'd2);
        check("restart_busy", 8'(busy), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Runtime-programmable frequency divider controller that generates a divided clock-level signal and a one-cycle clock-enable pulse, with division ratio changes requested over a req/ack handshake. A ratio change is always applied on a period boundary, so the output never produces runt pulses. It sits beside the fixed even/odd divider bank and serves consumers that need a ratio selected at run time instead of a hard-wired /2…/7 tap.

## Interface

**Parameters**
- `W`, default 4: ratio and counter width. Legal ratios are 2..2^W-1.
- `DEF_RATIO`, default 2: ratio loaded at reset. Must be in 2..2^W-1.

**Ports**
- `clk`, input, 1: sole clock.
- `rst`, input, 1: reset, synchronous and active-low.
- `en`, input, 1: run enable, level-sensitive.
- `div_req`, input, 1: ratio change request. Held until `div_ack` or `div_err`.
- `div_ratio`, input, W: requested ratio. Valid while `div_req` is high.
- `div_ack`, output, 1: one-cycle pulse when a request is accepted.
- `div_err`, output, 1: one-cycle pulse when a request is rejected (ratio < 2).
- `busy`, output, 1: an accepted change is pending and not yet applied.
- `cur_ratio`, output, W: ratio currently in effect.
- `div_out`, output, 1: divided waveform, period = `cur_ratio` cycles.
- `clk_en`, output, 1: one-cycle pulse, once per period.

## Operation

**Reset state** (`rst` = 0 at a clock edge): `state` = OFF, `cnt` = 0, `cur_ratio` = `DEF_RATIO`, `pend_ratio` = `DEF_RATIO`. All of `div_out`, `clk_en`, `div_ack`, `div_err` and `busy` are 0. Reset asserted mid-operation discards any pending change.

**FSM states**
- **OFF**: `cnt` is held at 0 and the outputs are low. If `en` = 1, go to RUN.
- **RUN**: `cnt` counts 0..`cur_ratio`-1 and wraps.
  - Accepted request → PEND.
  - `en` = 0 → DRAIN.
- **PEND**: counting continues with the old ratio. `busy` = 1.
  - At the wrap cycle (`cnt` == `cur_ratio`-1): `cur_ratio` ← `pend_ratio`, `cnt` ← 0, go to RUN.
  - If `en` = 0 is seen in PEND, go to DRAIN. The pending ratio is still applied at the wrap.
- **DRAIN**: counting finishes the current period. At the wrap, apply any pending ratio, then go to OFF.

**Request acceptance**
- A request is evaluated only in OFF or RUN. In PEND and DRAIN, `div_req` is stalled with no ack.
- `div_ratio` >= 2: latch it into `pend_ratio` and pulse `div_ack` on the next cycle.
  - In OFF, the ratio is applied immediately to `cur_ratio` and the state stays OFF.
  - In RUN, the state goes to PEND.
- `div_ratio` < 2: pulse `div_err` on the next cycle. No state change.
- A requester must drop `div_req` in the cycle after it sees ack or err. A `div_req` still high after that is treated as a new request.
- Requesting a ratio equal to `cur_ratio` is acked normally and still passes through PEND.

**Output decode**
- H = (`cur_ratio`+1)>>1, using the ceiling for odd ratios.
- `div_out` = 1 for `cnt` in 0..H-1.
  - Even ratios give a 50 % duty cycle.
  - Odd ratio N gives (N+1)/2 cycles high and (N-1)/2 cycles low.
- `clk_en` = 1 when `cnt` == `cur_ratio`-1.
- Both outputs are registered from `cnt` and `state`, so they lag `cnt` by one cycle. Both are 0 in the cycle following any cycle spent in OFF.

## Timing

- `en` sampled high in OFF at edge t:
  - RUN with `cnt` = 0 from t+1.
  - `div_out` first high at t+2.
  - First `clk_en` at t+1+`cur_ratio`.
- `div_ack` and `div_err` assert exactly one cycle after the accepting edge and last exactly 1 cycle.
- `busy` rises together with `div_ack`. It falls in the cycle the new `cur_ratio` becomes visible, which is the first cycle of the new period.
- `clk_en` spacing:
  - Equals the old ratio up to and including the switch boundary.
  - Equals the new ratio afterwards.
  - There is never a period of mixed length.
- `cur_ratio` output: registered, and updates on the boundary edge.
- `en` falling: `div_out` and `clk_en` stop only after the final `clk_en` of the current period. `div_out` is 0 from the cycle after that `clk_en`.
- `en` re-asserted during DRAIN: it is ignored until OFF is reached. Restart then follows the OFF rule.

## Structure

- Package `freq_div_pkg` contains:
  - the `state_t` enum {OFF, RUN, PEND, DRAIN};
  - the `MIN_RATIO` = 2 constant;
  - a `half_ratio()` function for the H computation, shared with the fixed divider bank.
- Sub-module `freq_div_cnt`, parameterised by W. It holds the wrapping counter plus the registered `div_out`/`clk_en` decode, with inputs `run`, `ratio` and `load0`.
- `freq_div_ctrl` holds the FSM, the handshake and `pend_ratio`/`cur_ratio`.

## Test plan

- **Reset then start:** release reset, `en` = 1. Expect `cur_ratio` = 2, `div_out` toggling 1,0,1,0 starting 2 cycles after `en`, and `clk_en` every 2 cycles.
- **Odd ratio:** with W = 4, request ratio 5 in OFF, then enable. Expect `div_ack` after 1 cycle, `div_out` pattern 1,1,1,0,0 repeating, and `clk_en` spacing 5.
- **Mid-run switch:** running at 7, request 3 at `cnt` = 2. Expect:
  - `div_ack` and `busy` high;
  - the current 7-cycle period completes;
  - the next `clk_en` intervals are 3;
  - `busy` falls as `cur_ratio` changes 7→3.
- **Rejected and stalled requests:**
  - Request ratio 1 → `div_err` pulse, `cur_ratio` unchanged.
  - A second request raised while `busy` → no ack until the boundary, then ack.
- **Disable drain:** at ratio 6, drop `en` at `cnt` = 1. Expect 4 more `div_out`/`clk_en` cycles finishing the period, then OFF with `div_out` = 0 and no further `clk_en`.
- **Reset mid-PEND:** assert `rst` = 0 while `busy` = 1. Expect `cur_ratio` = `DEF_RATIO`, `busy` = 0, and all outputs 0 on the next cycle.
